sync_bit_memory: RTL and testbench

- Parametrised, clocked successor to the 8x8 bit-cell memory.
- Stores DEPTH words of DATA_W bits.
- Single-port read/write interface with a request/busy handshake and a registered read path.
- Hardware clear sweep, run after reset and on demand.
- Sits between the address decoder/controller and the array consumers; replaces the per-cell latch/enable structure with one synchronous block.

---
 rtl/sync_bit_memory_if.sv | 41 ++++
 rtl/sync_bit_memory.sv | 165 ++++++++++++++++
 tb/tb_sync_bit_memory.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_bit_memory_if.sv
// -----------------------------------------------------------------------------
// sync_bit_memory_if
// Request/response bundle between the address decoder/controller (master) and
// the synchronous word memory (slave).
//   req      : operation request (master -> slave)
//   rw       : 1 = write, 0 = read
//   addr     : word address, ADDR_W bits
//   wdata    : write data, DATA_W bits
//   clr      : start a clear sweep
//   busy     : slave cannot accept req/clr this cycle
//   rdata    : registered read data
//   rvalid   : one-cycle pulse, rdata holds a new read result
//   addr_err : one-cycle pulse, accepted request addressed a missing word
//   par_err  : one-cycle pulse with rvalid, stored parity mismatch
// -----------------------------------------------------------------------------
interface sync_bit_memory_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              req;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              clr;
  logic              busy;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              addr_err;
  logic              par_err;

  modport master (
    output req, rw, addr, wdata, clr,
    input  busy, rdata, rvalid, addr_err, par_err
  );

  modport slave (
    input  req, rw, addr, wdata, clr,
    output busy, rdata, rvalid, addr_err, par_err
  );
endinterface

// File: rtl/sync_bit_memory.sv
// -----------------------------------------------------------------------------
// sync_bit_memory
// Single-port synchronous memory of DEPTH words x DATA_W bits with a
// request/busy handshake, a one-cycle registered read path and a hardware
// clear sweep that runs after reset and whenever clr is accepted.
//
// Ports:
//   clk   : single clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : sync_bit_memory_if.slave (req/rw/addr/wdata/clr in,
//           busy/rdata/rvalid/addr_err/par_err out, all outputs registered)
//
// Optional feature (compile-time macro MEM_PARITY_EN):
//   defined   : each word carries an even-parity bit written from wdata;
//               a read whose stored parity disagrees pulses par_err.
//   undefined : no parity storage, par_err is constant 0.
// -----------------------------------------------------------------------------
module sync_bit_memory #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              rst_n,
  sync_bit_memory_if.slave bus
);

`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  // DEPTH may equal 2**ADDR_W, so the bound needs one extra bit.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Build the stored word from write data (parity bit on top when enabled).
  function automatic logic [MEM_W-1:0] encode_word(input logic [DATA_W-1:0] d);
`ifdef MEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

`ifdef MEM_PARITY_EN
  // Even parity over data plus stored bit is 0 for an intact word.
  function automatic logic parity_bad(input logic [MEM_W-1:0] w);
    return ^w;
  endfunction
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic [MEM_W-1:0]  mem_d [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              addr_err_q, addr_err_d;
  logic              par_err_q, par_err_d;
  logic              busy_q, busy_d;
  logic              addr_ok_s;

  assign addr_ok_s = ({1'b0, bus.addr} < DEPTH_EXT);

  // Next-state, array update and output pulse computation.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mem_d      = mem_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    addr_err_d = 1'b0;
    par_err_d  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        // Sweep one word per cycle; req and clr are ignored here.
        mem_d[ptr_q] = '0;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (bus.clr) begin
          // clr wins over a simultaneous req, which is dropped.
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else if (bus.req) begin
          if (addr_ok_s) begin
            if (bus.rw) begin
              mem_d[bus.addr] = encode_word(bus.wdata);
            end else begin
              rdata_d  = mem_q[bus.addr][DATA_W-1:0];
              rvalid_d = 1'b1;
`ifdef MEM_PARITY_EN
              par_err_d = parity_bad(mem_q[bus.addr]);
`else
              par_err_d = 1'b0;
`endif
            end
          end else begin
            addr_err_d = 1'b1;
            if (!bus.rw) begin
              rdata_d  = '0;
              rvalid_d = 1'b1;
            end else begin
              rdata_d = rdata_q;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  // Control state and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      addr_err_q <= 1'b0;
      par_err_q  <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      addr_err_q <= addr_err_d;
      par_err_q  <= par_err_d;
      busy_q     <= busy_d;
    end
  end

  // Storage array; contents are not reset, the sweep zeroes them instead.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mem_q <= mem_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.addr_err = addr_err_q;
  assign bus.par_err  = par_err_q;

endmodule

// File: tb/tb_sync_bit_memory.sv
// -----------------------------------------------------------------------------
// tb_sync_bit_memory
// Directed bench for sync_bit_memory: one DEPTH=8 instance and one DEPTH=6
// instance sharing clock and reset. Inputs change 1 ns after a rising edge
// and outputs are sampled at that same point, so every check looks at the
// state registered by the edge just passed.
// -----------------------------------------------------------------------------
module tb_sync_bit_memory;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sync_bit_memory_if #(.DATA_W(8), .DEPTH(8)) if8 ();
  sync_bit_memory_if #(.DATA_W(8), .DEPTH(6)) if6 ();

  sync_bit_memory #(.DATA_W(8), .DEPTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  sync_bit_memory #(.DATA_W(8), .DEPTH(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(if6.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv8(input logic r, input logic w, input logic [2:0] a,
                      input logic [7:0] d, input logic c);
    if8.req = r; if8.rw = w; if8.addr = a; if8.wdata = d; if8.clr = c;
  endtask

  task automatic drv6(input logic r, input logic w, input logic [2:0] a,
                      input logic [7:0] d, input logic c);
    if6.req = r; if6.rw = w; if6.addr = a; if6.wdata = d; if6.clr = c;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drv8(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    drv6(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

    // ---- reset state
    tick();
    tick();
    chk("rst_busy",     32'(if8.busy),     32'd1);
    chk("rst_rvalid",   32'(if8.rvalid),   32'd0);
    chk("rst_rdata",    32'(if8.rdata),    32'h00);
    chk("rst_addr_err", 32'(if8.addr_err), 32'd0);
    chk("rst_par_err",  32'(if8.par_err),  32'd0);

    // ---- busy lasts DEPTH cycles after rst_n rises
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("init_busy8", 32'(if8.busy), 32'd1);
      chk("init_busy6", 32'(if6.busy), (k <= 6) ? 32'd1 : 32'd0);
      tick();
    end
    chk("init_busy8_end", 32'(if8.busy), 32'd0);

    // ---- every word reads 0 after the power-up sweep
    for (int a = 0; a < 8; a++) begin
      drv8(1'b1, 1'b0, 3'(a), 8'h00, 1'b0);
      tick();
      chk("init_rvalid", 32'(if8.rvalid), 32'd1);
      chk("init_rdata",  32'(if8.rdata),  32'h00);
    end
    drv8(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    chk("rvalid_pulse_end", 32'(if8.rvalid), 32'd0);

    // ---- write 0xA5 @3, read 3 then 4 back-to-back
    drv8(1'b1, 1'b1, 3'd3, 8'hA5, 1'b0);
    tick();
    chk("wr_rvalid", 32'(if8.rvalid), 32'd0);
    chk("wr_aerr",   32'(if8.addr_err), 32'd0);
    drv8(1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
    tick();
    chk("rd3_rvalid", 32'(if8.rvalid), 32'd1);
    chk("rd3_rdata",  32'(if8.rdata),  32'hA5);
    drv8(1'b1, 1'b0, 3'd4, 8'h00, 1'b0);
    tick();
    chk("rd4_rvalid", 32'(if8.rvalid), 32'd1);
    chk("rd4_rdata",  32'(if8.rdata),  32'h00);
    // a write must not disturb rdata
    drv8(1'b1, 1'b1, 3'd4, 8'h5A, 1'b0);
    tick();
    chk("wr_hold_rdata",  32'(if8.rdata),  32'h00);
    chk("wr_hold_rvalid", 32'(if8.rvalid), 32'd0);
    drv8(1'b1, 1'b0, 3'd4, 8'h00, 1'b0);
    tick();
    chk("rd4b_rdata", 32'(if8.rdata), 32'h5A);
    drv8(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    chk("idle_hold_rdata", 32'(if8.rdata), 32'h5A);

    // ---- DEPTH=6 out-of-range handling
    drv6(1'b1, 1'b1, 3'd5, 8'h77, 1'b0);
    tick();
    chk("d6_wr5_aerr", 32'(if6.addr_err), 32'd0);
    drv6(1'b1, 1'b1, 3'd7, 8'h33, 1'b0);
    tick();
    chk("d6_wr7_aerr",   32'(if6.addr_err), 32'd1);
    chk("d6_wr7_rvalid", 32'(if6.rvalid),   32'd0);
    drv6(1'b1, 1'b0, 3'd5, 8'h00, 1'b0);
    tick();
    chk("d6_rd5_aerr",  32'(if6.addr_err), 32'd0);
    chk("d6_rd5_rdata", 32'(if6.rdata),    32'h77);
    drv6(1'b1, 1'b0, 3'd7, 8'h00, 1'b0);
    tick();
    chk("d6_rd7_rvalid", 32'(if6.rvalid),   32'd1);
    chk("d6_rd7_rdata",  32'(if6.rdata),    32'h00);
    chk("d6_rd7_aerr",   32'(if6.addr_err), 32'd1);
    drv6(1'b1, 1'b0, 3'd6, 8'h00, 1'b0);
    tick();
    chk("d6_rd6_aerr",  32'(if6.addr_err), 32'd1);
    drv6(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    chk("d6_rd0_aerr",  32'(if6.addr_err), 32'd0);
    chk("d6_rd0_rdata", 32'(if6.rdata),    32'h00);
    drv6(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    chk("d6_aerr_end", 32'(if6.addr_err), 32'd0);

    // ---- fill with 0xFF, then clr together with a write
    for (int a = 0; a < 8; a++) begin
      drv8(1'b1, 1'b1, 3'(a), 8'hFF, 1'b0);
      tick();
    end
    drv8(1'b1, 1'b0, 3'd6, 8'h00, 1'b0);
    tick();
    chk("fill_rdata", 32'(if8.rdata), 32'hFF);
    drv8(1'b1, 1'b1, 3'd0, 8'h12, 1'b1);
    tick();
    chk("clr_busy", 32'(if8.busy), 32'd1);
    // reads requested while busy are ignored
    drv8(1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("clr_busy_hold", 32'(if8.busy),   32'd1);
      chk("clr_no_rvalid", 32'(if8.rvalid), 32'd0);
    end
    tick();
    chk("clr_busy_end", 32'(if8.busy),   32'd0);
    chk("clr_rvalid",   32'(if8.rvalid), 32'd0);
    chk("clr_rdata",    32'(if8.rdata),  32'hFF);
    for (int a = 0; a < 8; a++) begin
      drv8(1'b1, 1'b0, 3'(a), 8'h00, 1'b0);
      tick();
      chk("clr_rd_rvalid", 32'(if8.rvalid), 32'd1);
      chk("clr_rd_rdata",  32'(if8.rdata),  32'h00);
    end

    // ---- reset in the middle of a sweep restarts it
    drv8(1'b1, 1'b1, 3'd2, 8'h5C, 1'b0);
    tick();
    drv8(1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
    tick();
    chk("pre_rst_rdata", 32'(if8.rdata), 32'h5C);
    drv8(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    tick();
    drv8(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_rdata", 32'(if8.rdata), 32'h00);
    for (int k = 1; k <= 8; k++) begin
      chk("mid_rst_busy8", 32'(if8.busy), 32'd1);
      chk("mid_rst_busy6", 32'(if6.busy), (k <= 6) ? 32'd1 : 32'd0);
      tick();
    end
    chk("mid_rst_busy8_end", 32'(if8.busy), 32'd0);

`ifdef MEM_PARITY_EN
    // ---- parity: corrupt a stored data bit and read it back
    drv8(1'b1, 1'b1, 3'd2, 8'h01, 1'b0);
    tick();
    dut8.mem_q[2][0] = 1'b0;
    drv8(1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
    tick();
    chk("par_bad_rvalid", 32'(if8.rvalid),  32'd1);
    chk("par_bad_err",    32'(if8.par_err), 32'd1);
    chk("par_bad_rdata",  32'(if8.rdata),   32'h00);
    drv8(1'b1, 1'b1, 3'd5, 8'h03, 1'b0);
    tick();
    chk("par_wr_err", 32'(if8.par_err), 32'd0);
    drv8(1'b1, 1'b0, 3'd5, 8'h00, 1'b0);
    tick();
    chk("par_ok_rvalid", 32'(if8.rvalid),  32'd1);
    chk("par_ok_err",    32'(if8.par_err), 32'd0);
    chk("par_ok_rdata",  32'(if8.rdata),   32'h03);
`else
    drv8(1'b1, 1'b1, 3'd5, 8'h07, 1'b0);
    tick();
    drv8(1'b1, 1'b0, 3'd5, 8'h00, 1'b0);
    tick();
    chk("nopar_rdata", 32'(if8.rdata),   32'h07);
    chk("nopar_err",   32'(if8.par_err), 32'd0);
`endif
    drv8(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    chk("final_rvalid", 32'(if8.rvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
